// File: rtl/acorn128_ctrl.sv
// acorn128_ctrl: phase sequencer for the bit-serial ACORN-128 datapath.
// Walks one job through INIT, AD, AD_PAD, ENC, ENC_PAD and FINAL. Each cycle it
// decodes the step enable, message bit and ca/cb controls, emits ciphertext
// bits and collects the 128-bit tag from the keystream.
module acorn128_ctrl #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [127:0]     i_key,
    input  logic [127:0]     i_iv,
    input  logic [LEN_W-1:0] i_ad_len,
    input  logic [LEN_W-1:0] i_pt_len,
    input  logic             i_din_valid,
    input  logic             i_din,
    output logic             o_din_ready,
    input  logic             i_ks_bit,
    output logic             o_step_en,
    output logic             o_m_bit,
    output logic             o_ca,
    output logic             o_cb,
    output logic             o_ct_valid,
    output logic             o_ct_bit,
    output logic [127:0]     o_tag,
    output logic             o_tag_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       o_phase
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StInit   = 3'd1;
    localparam logic [2:0] StAd     = 3'd2;
    localparam logic [2:0] StAdPad  = 3'd3;
    localparam logic [2:0] StEnc    = 3'd4;
    localparam logic [2:0] StEncPad = 3'd5;
    localparam logic [2:0] StFinal  = 3'd6;
    localparam logic [2:0] StDone   = 3'd7;

    localparam logic [10:0] InitLast  = 11'd1791;
    localparam logic [10:0] PadLast   = 11'd255;
    localparam logic [10:0] FinalLast = 11'd767;

    logic [2:0]       r_state;
    logic [10:0]      r_step;
    logic [LEN_W-1:0] r_len_cnt;
    logic [127:0]     r_key;
    logic [127:0]     r_iv;
    logic [LEN_W-1:0] r_ad_len;
    logic [LEN_W-1:0] r_pt_len;
    logic [127:0]     r_tag;
    logic             r_tag_valid;

    logic [2:0] w_state_nxt;
    logic       w_step_en;
    logic       w_m_bit;
    logic       w_ca;
    logic       w_cb;
    logic       w_din_ready;
    logic       w_ct_valid;
    logic       w_ct_bit;
    logic       w_init_m;
    logic       w_count_steps;
    logic       w_ad_last;
    logic       w_pt_last;
    logic       w_accept;

    assign w_accept  = (r_state == StIdle) && i_start;
    assign w_ad_last = (r_len_cnt == r_ad_len - LEN_W'(1));
    assign w_pt_last = (r_len_cnt == r_pt_len - LEN_W'(1));

    // Fixed-length phases advance r_step; data phases advance r_len_cnt instead.
    assign w_count_steps = (r_state == StInit) || (r_state == StAdPad) ||
                           (r_state == StEncPad) || (r_state == StFinal);

    // INIT message: key, then IV, then key with bit 0 flipped once at step 256.
    always_comb begin
        if (r_step == 11'd256) begin
            w_init_m = ~r_key[0];
        end else if (r_step[10:7] == 4'd1) begin
            w_init_m = r_iv[r_step[6:0]];
        end else begin
            w_init_m = r_key[r_step[6:0]];
        end
    end

    // Per-state decode of datapath controls and next state.
    always_comb begin
        w_state_nxt = r_state;
        w_step_en   = 1'b0;
        w_m_bit     = 1'b0;
        w_ca        = 1'b0;
        w_cb        = 1'b0;
        w_din_ready = 1'b0;
        w_ct_valid  = 1'b0;
        w_ct_bit    = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) w_state_nxt = StInit;
            end
            StInit: begin
                w_step_en = 1'b1;
                w_m_bit   = w_init_m;
                w_ca      = 1'b1;
                w_cb      = 1'b1;
                if (r_step == InitLast) begin
                    w_state_nxt = (r_ad_len != '0) ? StAd : StAdPad;
                end
            end
            StAd: begin
                w_din_ready = 1'b1;
                w_step_en   = i_din_valid;
                w_m_bit     = i_din;
                w_ca        = 1'b1;
                w_cb        = 1'b1;
                if (i_din_valid && w_ad_last) w_state_nxt = StAdPad;
            end
            StAdPad: begin
                w_step_en = 1'b1;
                w_m_bit   = (r_step == 11'd0);
                w_ca      = ~r_step[7];
                w_cb      = 1'b1;
                if (r_step == PadLast) begin
                    w_state_nxt = (r_pt_len != '0) ? StEnc : StEncPad;
                end
            end
            StEnc: begin
                w_din_ready = 1'b1;
                w_step_en   = i_din_valid;
                w_m_bit     = i_din;
                w_ca        = 1'b1;
                w_ct_valid  = i_din_valid;
                w_ct_bit    = i_din_valid & (i_din ^ i_ks_bit);
                if (i_din_valid && w_pt_last) w_state_nxt = StEncPad;
            end
            StEncPad: begin
                w_step_en = 1'b1;
                w_m_bit   = (r_step == 11'd0);
                w_ca      = ~r_step[7];
                if (r_step == PadLast) w_state_nxt = StFinal;
            end
            StFinal: begin
                w_step_en = 1'b1;
                w_ca      = 1'b1;
                w_cb      = 1'b1;
                if (r_step == FinalLast) w_state_nxt = StDone;
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Step and length counters, both cleared on every state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step    <= '0;
            r_len_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_step    <= '0;
            r_len_cnt <= '0;
        end else begin
            if (w_count_steps) r_step <= r_step + 11'd1;
            if ((r_state == StAd || r_state == StEnc) && i_din_valid) begin
                r_len_cnt <= r_len_cnt + LEN_W'(1);
            end
        end
    end

    // Job parameters, captured only when a start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key    <= '0;
            r_iv     <= '0;
            r_ad_len <= '0;
            r_pt_len <= '0;
        end else if (w_accept) begin
            r_key    <= i_key;
            r_iv     <= i_iv;
            r_ad_len <= i_ad_len;
            r_pt_len <= i_pt_len;
        end
    end

    // Tag capture over FINAL steps 640..767; valid set on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
        end else if (w_accept) begin
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
        end else if (r_state == StFinal) begin
            if (r_step[10:7] == 4'd5) r_tag[r_step[6:0]] <= i_ks_bit;
            if (r_step == FinalLast) r_tag_valid <= 1'b1;
        end
    end

    assign o_step_en   = w_step_en;
    assign o_m_bit     = w_m_bit;
    assign o_ca        = w_ca;
    assign o_cb        = w_cb;
    assign o_din_ready = w_din_ready;
    assign o_ct_valid  = w_ct_valid;
    assign o_ct_bit    = w_ct_bit;
    assign o_tag       = r_tag;
    assign o_tag_valid = r_tag_valid;
    assign o_busy      = (r_state != StIdle);
    assign o_done      = (r_state == StDone);
    assign o_phase     = r_state;

endmodule

// File: tb/tb_acorn128_ctrl.sv
// Scoreboard bench for acorn128_ctrl: stimulus queues the expected per-step
// controls and job-end results; a negedge monitor pops and compares them.
module tb_acorn128_ctrl;

    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [127:0]     i_key;
    logic [127:0]     i_iv;
    logic [LEN_W-1:0] i_ad_len;
    logic [LEN_W-1:0] i_pt_len;
    logic             i_din_valid;
    logic             i_din;
    logic             o_din_ready;
    logic             i_ks_bit;
    logic             o_step_en;
    logic             o_m_bit;
    logic             o_ca;
    logic             o_cb;
    logic             o_ct_valid;
    logic             o_ct_bit;
    logic [127:0]     o_tag;
    logic             o_tag_valid;
    logic             o_busy;
    logic             o_done;
    logic [2:0]       o_phase;

    acorn128_ctrl #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_key       (i_key),
        .i_iv        (i_iv),
        .i_ad_len    (i_ad_len),
        .i_pt_len    (i_pt_len),
        .i_din_valid (i_din_valid),
        .i_din       (i_din),
        .o_din_ready (o_din_ready),
        .i_ks_bit    (i_ks_bit),
        .o_step_en   (o_step_en),
        .o_m_bit     (o_m_bit),
        .o_ca        (o_ca),
        .o_cb        (o_cb),
        .o_ct_valid  (o_ct_valid),
        .o_ct_bit    (o_ct_bit),
        .o_tag       (o_tag),
        .o_tag_valid (o_tag_valid),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_phase     (o_phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic       m;
        logic       ca;
        logic       cb;
        logic       rdy;
        logic       ctv;
        logic       ctb;
    } step_t;

    typedef struct {
        int unsigned  cyc;
        int unsigned  nstep;
        int unsigned  nct;
        logic [127:0] tag;
    } done_t;

    step_t       q_step[$];
    done_t       q_done[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_step(input logic [2:0] ph, input logic m, input logic ca, input logic cb,
                             input logic rdy, input logic ctv, input logic ctb);
        step_t s;
        s = '{ph: ph, m: m, ca: ca, cb: cb, rdy: rdy, ctv: ctv, ctb: ctb};
        q_step.push_back(s);
    endtask

    // Monitor: one scoreboard pop per step_en, one per done pulse.
    initial begin
        int unsigned m_nstep;
        int unsigned m_nct;
        step_t       act;
        step_t       exp;
        done_t       d;
        m_nstep = 0;
        m_nct   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_nstep = 0;
                m_nct   = 0;
            end else begin
                if (o_step_en) begin
                    act = '{ph: o_phase, m: o_m_bit, ca: o_ca, cb: o_cb, rdy: o_din_ready,
                            ctv: o_ct_valid, ctb: o_ct_bit & o_ct_valid};
                    if (q_step.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_step: got step %h at cycle %0d, want none", act, cyc);
                    end else begin
                        exp = q_step.pop_front();
                        check($sformatf("step%0d", m_nstep), 128'(act), 128'(exp));
                    end
                    m_nstep++;
                end
                if (o_ct_valid) begin
                    m_nct++;
                    if (!o_step_en) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL ct_without_step: got ct_valid=1 step_en=0, want step_en=1");
                    end
                end
                if (o_done) begin
                    if (q_done.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_done: got done at cycle %0d, want none", cyc);
                    end else begin
                        d = q_done.pop_front();
                        check("done_cycle", 128'(cyc), 128'(d.cyc));
                        check("step_count", 128'(m_nstep), 128'(d.nstep));
                        check("ct_count", 128'(m_nct), 128'(d.nct));
                        check("tag", o_tag, d.tag);
                        check("tag_valid_at_done", 128'(o_tag_valid), 128'(1));
                        check("done_phase", 128'(o_phase), 128'(7));
                    end
                    m_nstep = 0;
                    m_nct   = 0;
                end
            end
        end
    end

    // One job. abort_at >= 0 asserts reset in place of that AD step.
    task automatic run_job(input logic [127:0] k, input logic [127:0] v, input int adl,
                           input int ptl, input logic [31:0] adb, input logic [31:0] ptb,
                           input bit stall, input bit inv, input bit busy_start,
                           input int abort_at);
        int           n_ad;
        int           stalls;
        done_t        d;
        logic [127:0] exp_tag;
        logic         m;
        exp_tag = inv ? {32{4'h5}} : {32{4'hA}};
        n_ad    = (abort_at >= 0) ? abort_at : adl;
        stalls  = (stall && ptl > 0) ? ptl - 1 : 0;

        for (int i = 0; i < 1792; i++) begin
            if (i < 128)       m = k[i];
            else if (i < 256)  m = v[i - 128];
            else if (i == 256) m = ~k[0];
            else               m = k[i % 128];
            push_step(3'd1, m, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int b = 0; b < n_ad; b++) push_step(3'd2, adb[b], 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        if (abort_at < 0) begin
            for (int s = 0; s < 256; s++)
                push_step(3'd3, s == 0, s < 128, 1'b1, 1'b0, 1'b0, 1'b0);
            for (int b = 0; b < ptl; b++)
                push_step(3'd4, ptb[b], 1'b1, 1'b0, 1'b1, 1'b1, ~ptb[b]);
            for (int s = 0; s < 256; s++)
                push_step(3'd5, s == 0, s < 128, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int s = 0; s < 768; s++)
                push_step(3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        i_key       = k;
        i_iv        = v;
        i_ad_len    = LEN_W'(adl);
        i_pt_len    = LEN_W'(ptl);
        i_start     = 1'b1;
        i_din_valid = 1'b0;
        i_ks_bit    = 1'b1;
        if (abort_at < 0) begin
            d.cyc   = cyc + 3073 + adl + ptl + stalls;
            d.nstep = 3072 + adl + ptl;
            d.nct   = ptl;
            d.tag   = exp_tag;
            q_done.push_back(d);
        end
        tick();
        i_start = 1'b0;
        check("tag_clear_on_start", o_tag, '0);
        check("tag_valid_clear_on_start", 128'(o_tag_valid), 128'(0));

        for (int s = 0; s < 1792; s++) begin
            if (busy_start && s == 10) begin
                i_start  = 1'b1;
                i_key    = ~k;
                i_iv     = ~v;
                i_ad_len = '0;
                i_pt_len = '0;
            end else begin
                i_start = 1'b0;
            end
            tick();
        end
        i_start = 1'b0;

        for (int b = 0; b < adl; b++) begin
            i_din_valid = 1'b1;
            i_din       = adb[b];
            if (b == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_outputs", 128'({o_din_ready, o_step_en, o_m_bit, o_ca, o_cb,
                      o_ct_valid, o_ct_bit, o_busy, o_done, o_tag_valid}), 128'(0));
                check("rst_phase", 128'(o_phase), 128'(0));
                check("rst_tag", o_tag, '0);
                tick();
                rst         = 1'b0;
                i_din_valid = 1'b0;
                repeat (8) tick();
                check("abort_queue_empty", 128'(q_step.size()), 128'(0));
                check("abort_idle_phase", 128'(o_phase), 128'(0));
                return;
            end
            tick();
        end
        i_din_valid = 1'b0;

        repeat (256) tick();

        for (int b = 0; b < ptl; b++) begin
            if (stall && b > 0) begin
                i_din_valid = 1'b0;
                i_din       = ~ptb[b];
                tick();
            end
            i_din_valid = 1'b1;
            i_din       = ptb[b];
            i_ks_bit    = 1'b1;
            tick();
        end
        i_din_valid = 1'b0;

        repeat (256) tick();
        for (int s = 0; s < 768; s++) begin
            i_ks_bit = s[0] ^ inv;
            tick();
        end
        i_ks_bit = 1'b0;
        tick();
        repeat (4) tick();
        check("hold_tag_valid", 128'(o_tag_valid), 128'(1));
        check("hold_tag", o_tag, exp_tag);
        check("idle_phase", 128'(o_phase), 128'(0));
        check("idle_busy", 128'(o_busy), 128'(0));
    endtask

    initial begin
        rst         = 1'b1;
        i_start     = 1'b0;
        i_key       = '0;
        i_iv        = '0;
        i_ad_len    = '0;
        i_pt_len    = '0;
        i_din_valid = 1'b0;
        i_din       = 1'b0;
        i_ks_bit    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 128'({o_din_ready, o_step_en, o_m_bit, o_ca, o_cb, o_ct_valid,
              o_ct_bit, o_busy, o_done, o_tag_valid}), 128'(0));
        check("reset_phase", 128'(o_phase), 128'(0));
        check("reset_tag", o_tag, '0);
        tick();
        rst = 1'b0;
        tick();

        // Empty job with the reference key and all-ones IV.
        run_job(128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, {128{1'b1}}, 0, 0,
                32'h0, 32'h0, 1'b0, 1'b0, 1'b0, -1);
        // Padding job with a start pulse ignored mid-INIT.
        run_job(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555,
                128'h0F0F_1234_5678_9ABC_DEF0_F0F0_A5A5_5A5A, 8, 16,
                32'h0000_00A5, 32'h0000_3C96, 1'b0, 1'b1, 1'b1, -1);
        // Encryption with alternating din_valid stalls.
        run_job(128'hFFFF_0000_FFFF_0000_1357_9BDF_2468_ACE0,
                128'h8000_0000_0000_0000_0000_0000_0000_0001, 4, 16,
                32'h0000_0009, 32'h0000_F00D, 1'b1, 1'b0, 1'b0, -1);
        // Reset at AD step 3.
        run_job(128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
                128'h0F0F_1234_5678_9ABC_DEF0_F0F0_A5A5_5A5A, 8, 0,
                32'h0000_00C3, 32'h0, 1'b0, 1'b0, 1'b0, 3);
        // Single-bit AD and plaintext after recovery.
        run_job(128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555,
                128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 1, 1,
                32'h1, 32'h1, 1'b0, 1'b0, 1'b0, -1);

        check("final_step_queue_empty", 128'(q_step.size()), 128'(0));
        check("final_done_queue_empty", 128'(q_done.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acorn128_ctrl.md
# acorn128_ctrl

Phase sequencer for the bit-serial ACORN-128 datapath (state_update128 plus ksg128). It walks one authenticated-encryption job through six phases: initialization, associated data, AD padding, encryption, encryption padding and finalization. For every state-update step it produces the step enable, message bit and ca/cb control bits. It also emits ciphertext bits and collects the 128-bit tag from the keystream.

## Interface
- LEN_W, default 16: width of the AD and plaintext bit-length inputs and their counters.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle job request; honoured only in IDLE.
- key  in  128  key, latched at accepted start.
- iv  in  128  IV, latched at accepted start.
- ad_len  in  LEN_W  AD length in bits, latched at start.
- pt_len  in  LEN_W  plaintext length in bits, latched at start.
- din_valid  in  1  serial AD/plaintext bit valid.
- din  in  1  serial AD/plaintext bit, LSB-first.
- din_ready  out  1  controller consumes din this cycle if din_valid.
- ks_bit  in  1  current keystream bit from ksg128, valid before the update.
- step_en  out  1  datapath performs one state update this cycle.
- m_bit  out  1  message bit for the update.
- ca  out  1  ca control bit.
- cb  out  1  cb control bit.
- ct_valid  out  1  ct_bit valid.
- ct_bit  out  1  din ^ ks_bit.
- tag  out  128  authentication tag.
- tag_valid  out  1  tag complete; held until next accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at job end.
- phase  out  3  current state encoding.

## Operation
- States and phase encodings: IDLE=0, INIT=1, AD=2, AD_PAD=3, ENC=4, ENC_PAD=5, FINAL=6, DONE=7.
- Step counter: 11 bits, cleared on every state entry.
- Length counters: LEN_W bits; count consumed data bits.
- IDLE: start latches key, iv, ad_len and pt_len, clears tag and tag_valid, then moves to INIT.
- INIT: 1792 steps with ca=1, cb=1. step_en is 1 every cycle. m_bit by step i:
  - i<128: key[i].
  - 128≤i<256: iv[i-128].
  - i=256: key[0]^1.
  - 257≤i<1792: key[i mod 128].
- After INIT: go to AD if ad_len≠0, else AD_PAD.
- AD: din_ready=1. step_en=din_valid, m_bit=din, ca=1, cb=1. Go to AD_PAD after ad_len bits are consumed.
- AD_PAD: 256 steps. m_bit=1 at step 0, 0 otherwise. ca=1 for steps 0–127, 0 for steps 128–255. cb=1.
- After AD_PAD: go to ENC if pt_len≠0, else ENC_PAD.
- ENC: din_ready=1. step_en=din_valid, m_bit=din, ca=1, cb=0. ct_valid=step_en, ct_bit=din^ks_bit. Go to ENC_PAD after pt_len bits are consumed.
- ENC_PAD: 256 steps with the same m_bit/ca pattern as AD_PAD, but cb=0.
- FINAL: 768 steps with m_bit=0, ca=1, cb=1. At step 640+j (j=0..127), tag[j] captures ks_bit.
- DONE: step_en=0, done=1, tag_valid is set; then return to IDLE.
- Width rules: the counters do not wrap. Phase exit compares the counter against its terminal value (terminal−1 at the final step).

## Timing
- Reset values: state IDLE; tag=0; every output 0, including phase.
- Registers: state, counters and tag are registered.
- Combinational outputs: step_en, m_bit, ca, cb, din_ready, ct_valid and ct_bit are decoded from the current state, counter and din_valid.
- Start latency: start in cycle t gives INIT step 0 (step_en=1) in cycle t+1.
- Job length: with din_valid held high, total step_en count is 3072+ad_len+pt_len. DONE follows the last FINAL step by one cycle.
- Stall: din_valid=0 in AD or ENC gives step_en=0 and ct_valid=0. Counters and state hold; there is no bubble penalty on resume.
- Start while busy: ignored. Latched key, IV and lengths are unaffected.
- Reset mid-job: returns to IDLE immediately. tag and tag_valid clear; no done pulse.
- ad_len=0 or pt_len=0: the corresponding data state is skipped entirely, with no cycle spent in it.
- Max length: 2^LEN_W−1 bits is accepted with no counter overflow.

## Test plan
- Empty job: ad_len=0, pt_len=0, din_valid=0.
  - Exactly 3072 step_en pulses; phase sequence 1,3,5,6,7,0.
  - done high at cycle 3073 after start.
- INIT message: key=0x0123…CDEF, iv=all ones.
  - m_bit=key[0] at step 0 and iv[0]=1 at step 128.
  - m_bit=key[0]^1 at step 256 and key[3] at step 1795 mod 128 position (step 259).
  - ca=cb=1 throughout INIT.
- Padding pattern (ad_len=8, pt_len=16):
  - In AD_PAD, m_bit=1 only at step 0 and ca drops to 0 at step 128, with cb=1.
  - ENC_PAD shows the same ca pattern, with cb=0.
- ENC with stalls: pt_len=16, din_valid toggled 1,0,1,…, ks_bit=1.
  - 16 ct_valid pulses, each with ct_bit=~din.
  - Step counter frozen during stalls; total job cycles grow by the stall count.
- Tag capture: ks_bit driven as (FINAL step index)[0].
  - tag = 0xAAAA…AAAA, i.e. tag[j] = j[0].
  - tag_valid rises with done and holds until the next start.
- Reset and start-while-busy:
  - rst asserted at AD step 3 gives phase=0 and all outputs 0 on the next sample.
  - start pulsed during INIT does not change the latched key or the step count.
